pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage of the multicycle CPU, sitting directly downstream of the PC-source multiplexer. It holds the architectural PC and the exception PC (EPC). It decides each cycle whether the muxed next-PC value is committed: unconditional write, or conditional write gated by the branch comparison. It flags misaligned targets and counts committed PC updates for debug.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of PC/EPC/counter
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `EPC_RESET`, 32'h0000_0000, EPC value after reset

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `pc_next`  in  WIDTH  candidate PC from the PC-source mux
- `pc_write`  in  1  unconditional PC load request
- `pc_write_cond`  in  1  conditional (branch) PC load request
- `branch_op`  in  2  branch condition select
- `alu_zero`  in  1  ALU zero flag
- `alu_lt`  in  1  ALU less-than flag
- `alu_gt`  in  1  ALU greater-than flag
- `epc_write`  in  1  capture `epc_in` into EPC
- `epc_in`  in  WIDTH  value to save as EPC (normally PC-4 from ALU)
- `fault_clear`  in  1  clears sticky misalign fault
- `pc`  out  WIDTH  current PC
- `epc`  out  WIDTH  current EPC
- `pc_loaded`  out  1  one-cycle pulse: PC was updated on previous edge
- `misalign_fault`  out  1  sticky: a load with `pc_next[1:0]!=0` was rejected
- `update_count`  out  WIDTH  number of committed PC loads since reset

## Operation
- Branch condition `take`, by `branch_op`:
  - 00 BEQ: `alu_zero`
  - 01 BNE: `!alu_zero`
  - 10 BLE: `alu_lt | alu_zero`
  - 11 BGT: `alu_gt`
- Load request: `req = pc_write | (pc_write_cond & take)`. `pc_write` dominates, and the condition is ignored when it is high.
- Alignment check: `req & pc_next[1:0]==2'b00` → PC ← `pc_next`.
- `req` with a misaligned target:
  - PC holds.
  - `misalign_fault` ← 1.
  - The counter does not increment.
  - `pc_loaded` stays 0.
- `misalign_fault` clearing:
  - Cleared by `fault_clear`.
  - If `fault_clear` and a new misaligned `req` occur in the same cycle, set wins (fault stays 1).
- `epc_write` → EPC ← `epc_in`. No alignment check. Independent of PC load; both may happen in the same cycle.
- `update_count`: +1 per committed load. Wraps from all-ones to 0 without a flag.
- `pc_loaded`: registered copy of "commit happened this edge".
- No `req` → PC holds. Unused flag inputs have no effect.

## Timing
- All state updates on rising `clk`. Enables and flags are sampled at the same edge, and the new PC is visible the following cycle (1-cycle latency).
- Values after reset:
  - `pc`=`RESET_PC`
  - `epc`=`EPC_RESET`
  - `pc_loaded`=0
  - `misalign_fault`=0
  - `update_count`=0
- `reset` has priority over every other input in the same cycle. Reset asserted mid-sequence, e.g. together with `pc_write`, discards the load.
- `pc_loaded` is high for exactly the cycle after a committed load. Back-to-back loads keep it high continuously.
- Flags are consumed combinationally in the same cycle as `pc_write_cond`. The controller must hold them stable across that edge.
- Control state: two-state commit tracker, IDLE → LOADED on commit, LOADED → IDLE when no commit; `pc_loaded` = (state==LOADED). Reset → IDLE.

## Structure
- Shared CPU package holds:
  - `branch_op` encodings (`BR_BEQ`, `BR_BNE`, `BR_BLE`, `BR_BGT`)
  - `RESET_PC` / `EPC_RESET` default constants
  - the 2-bit commit-state typedef
- One natural sub-module: `branch_cond_eval`, combinational `branch_op` + flags → `take`. It is reused by the control unit for debug.
- Everything else (PC reg, EPC reg, fault flag, counter, commit tracker) stays in `pc_unit`.

## Test plan
- Reset check: hold `reset` 2 cycles, then release with no requests → `pc`=0, `epc`=0, `update_count`=0, `pc_loaded`=0 for 3 further cycles.
- Unconditional write: `pc_write`=1, `pc_next`=32'h0000_0004 for one cycle → next cycle `pc`=4, `pc_loaded`=1, `update_count`=1. One cycle later `pc_loaded`=0.
- BEQ vs BNE with flags not matching the condition:
  - `pc_write_cond`=1, `branch_op`=00, `alu_zero`=0, `pc_next`=32'h40 → `pc` unchanged.
  - Repeat with `branch_op`=01 → `pc`=32'h40.
- Misaligned target, then clear: `pc_write`=1, `pc_next`=32'h0000_0042 → `pc` holds, `misalign_fault`=1, count unchanged. Then `fault_clear` → `misalign_fault`=0.
- Simultaneous events, same cycle: `pc_write`=1 (`pc_next`=32'h80), `epc_write`=1 (`epc_in`=32'h1C), `reset`=0 → `pc`=32'h80 and `epc`=32'h1C next cycle.
- Reset during activity: issue the same stimulus as the simultaneous-events case with `reset`=1 → `pc`=`RESET_PC`, `epc`=`EPC_RESET`, count=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared CPU constants, branch encodings and commit-state type
package pc_unit_pkg;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLE = 2'b10,
        BR_BGT = 2'b11
    } branchOp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOADED = 2'b01
    } commitState_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] EPC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_unit_branch_cond_eval.sv
// branch_cond_eval: combinational branch condition from branch_op and ALU flags
module branch_cond_eval
    import pc_unit_pkg::*;
(
    input  logic [1:0] branchOp,
    input  logic       aluZero,
    input  logic       aluLt,
    input  logic       aluGt,
    output logic       take
);

    // select the flag combination the current branch kind tests
    always_comb begin
        take = branchOp == BR_BEQ ? aluZero :
               branchOp == BR_BNE ? !aluZero :
               branchOp == BR_BLE ? (aluLt | aluZero) : aluGt;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC/EPC registers with gated commit, misalign fault and load counter
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = WIDTH'(RESET_PC_DEFAULT),
    parameter logic [WIDTH-1:0]   EPC_RESET = WIDTH'(EPC_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic [1:0]       branch_op,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_gt,
    input  logic             epc_write,
    input  logic [WIDTH-1:0] epc_in,
    input  logic             fault_clear,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             pc_loaded,
    output logic             misalign_fault,
    output logic [WIDTH-1:0] update_count
);

    logic         take;
    logic         req;
    logic         commit;
    logic         reject;
    commitState_t stateQ;
    commitState_t stateD;

    branch_cond_eval uBranchCond (
        .branchOp (branch_op),
        .aluZero  (alu_zero),
        .aluLt    (alu_lt),
        .aluGt    (alu_gt),
        .take     (take)
    );

    // a request commits only to a word-aligned target; otherwise it is rejected
    always_comb begin
        req    = pc_write | (pc_write_cond & take);
        commit = req & (pc_next[1:0] == 2'b00);
        reject = req & (pc_next[1:0] != 2'b00);
    end

    // commit tracker: LOADED for exactly the cycles following a commit
    always_comb begin
        stateD    = commit ? LOADED : IDLE;
        pc_loaded = stateQ == LOADED;
    end

    // commit-tracker state register
    always_ff @(posedge clk) begin
        if (reset) stateQ <= IDLE;
        else stateQ <= stateD;
    end

    // PC, EPC, sticky fault (set beats clear) and wrapping commit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            epc            <= EPC_RESET;
            misalign_fault <= 1'b0;
            update_count   <= '0;
        end else begin
            if (commit) pc <= pc_next;
            if (epc_write) epc <= epc_in;
            misalign_fault <= reject | (misalign_fault & !fault_clear);
            if (commit) update_count <= update_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plan plus randomized stimulus against a behavioural PC model
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_op;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_gt;
    logic        epc_write;
    logic [31:0] epc_in;
    logic        fault_clear;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pc_loaded;
    logic        misalign_fault;
    logic [31:0] update_count;

    int nCmp = 0;
    int nBad = 0;
    bit started = 1'b0;

    logic [31:0] mPc, mEpc, mCount;
    logic        mLoaded, mFault;

    pc_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_next        (pc_next),
        .pc_write       (pc_write),
        .pc_write_cond  (pc_write_cond),
        .branch_op      (branch_op),
        .alu_zero       (alu_zero),
        .alu_lt         (alu_lt),
        .alu_gt         (alu_gt),
        .epc_write      (epc_write),
        .epc_in         (epc_in),
        .fault_clear    (fault_clear),
        .pc             (pc),
        .epc            (epc),
        .pc_loaded      (pc_loaded),
        .misalign_fault (misalign_fault),
        .update_count   (update_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: the architectural effect of one clock edge
    always @(posedge clk) begin
        logic [3:0] takeTab;
        logic       doReq;
        if (reset) begin
            mPc = 32'h0; mEpc = 32'h0; mCount = 32'h0; mLoaded = 1'b0; mFault = 1'b0;
        end else begin
            takeTab = {alu_gt, alu_lt | alu_zero, !alu_zero, alu_zero};
            doReq   = pc_write || (pc_write_cond && takeTab[branch_op]);
            mLoaded = doReq && (pc_next % 4 == 0);
            if (mLoaded) begin
                mPc    = pc_next;
                mCount = mCount + 1;
            end
            if (doReq && (pc_next % 4 != 0)) mFault = 1'b1;
            else if (fault_clear) mFault = 1'b0;
            if (epc_write) mEpc = epc_in;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("pc", pc, mPc);
            check("epc", epc, mEpc);
            check("pc_loaded", {31'b0, pc_loaded}, {31'b0, mLoaded});
            check("misalign_fault", {31'b0, misalign_fault}, {31'b0, mFault});
            check("update_count", update_count, mCount);
        end
    end

    task automatic quiet();
        pc_write = 0; pc_write_cond = 0; branch_op = 0; alu_zero = 0; alu_lt = 0; alu_gt = 0;
        epc_write = 0; epc_in = 0; fault_clear = 0; pc_next = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        tick();
        tick();
        reset = 1'b0;
        started = 1'b1;
        repeat (3) begin
            tick();
            check("rst_pc", pc, 32'h0);
            check("rst_epc", epc, 32'h0);
            check("rst_count", update_count, 32'h0);
            check("rst_loaded", {31'b0, pc_loaded}, 32'h0);
        end
        pc_write = 1; pc_next = 32'h4;
        tick();
        quiet();
        check("uncond_pc", pc, 32'h4);
        check("uncond_loaded", {31'b0, pc_loaded}, 32'h1);
        check("uncond_count", update_count, 32'h1);
        tick();
        check("uncond_loaded_drop", {31'b0, pc_loaded}, 32'h0);
        pc_write_cond = 1; branch_op = 2'b00; alu_zero = 0; pc_next = 32'h40;
        tick();
        check("beq_not_taken", pc, 32'h4);
        branch_op = 2'b01;
        tick();
        quiet();
        check("bne_taken", pc, 32'h40);
        check("bne_count", update_count, 32'h2);
        pc_write = 1; pc_next = 32'h42;
        tick();
        quiet();
        check("mis_pc_hold", pc, 32'h40);
        check("mis_fault", {31'b0, misalign_fault}, 32'h1);
        check("mis_count", update_count, 32'h2);
        check("mis_loaded", {31'b0, pc_loaded}, 32'h0);
        fault_clear = 1;
        tick();
        check("fault_cleared", {31'b0, misalign_fault}, 32'h0);
        pc_write = 1; pc_next = 32'h43;
        tick();
        quiet();
        check("set_wins", {31'b0, misalign_fault}, 32'h1);
        fault_clear = 1;
        tick();
        quiet();
        pc_write = 1; pc_next = 32'h80; epc_write = 1; epc_in = 32'h1C;
        tick();
        quiet();
        check("simul_pc", pc, 32'h80);
        check("simul_epc", epc, 32'h1C);
        pc_write = 1; pc_next = 32'h80; epc_write = 1; epc_in = 32'h1C; reset = 1;
        tick();
        quiet();
        reset = 0;
        check("rst_act_pc", pc, 32'h0);
        check("rst_act_epc", epc, 32'h0);
        check("rst_act_count", update_count, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(63) == 0);
            pc_write      = ($urandom_range(3) == 0);
            pc_write_cond = $urandom_range(1);
            branch_op     = 2'($urandom_range(3));
            alu_zero      = $urandom_range(1);
            alu_lt        = $urandom_range(1);
            alu_gt        = $urandom_range(1);
            epc_write     = ($urandom_range(3) == 0);
            epc_in        = $urandom;
            fault_clear   = ($urandom_range(7) == 0);
            pc_next       = $urandom;
            if ($urandom_range(3) != 0) pc_next[1:0] = 2'b00;
            tick();
        end
        quiet();
        reset = 0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
